// File: rtl/debounce_buttons_multi.sv
// Multi-channel button debouncer with press/release/long-press pulses and a toggle flag per channel.
// Define DEBOUNCE_REPEAT_EN to add auto-repeat press pulses while a button stays in the long-press state.
module debounce_buttons_multi #(
   parameter int NUM_BTNS     = 4,
   parameter int STABLE_TICKS = 50,
   parameter int LONG_TICKS   = 1000,
   parameter int REPEAT_TICKS = 200
) (
   input  logic                in_clk,
   input  logic                in_rst,
   input  logic [NUM_BTNS-1:0] in_signal,
   output logic [NUM_BTNS-1:0] out_debounced,
   output logic [NUM_BTNS-1:0] out_pressed,
   output logic [NUM_BTNS-1:0] out_released,
   output logic [NUM_BTNS-1:0] out_long,
   output logic [NUM_BTNS-1:0] out_toggled
);

   localparam int MAX_SL  = (STABLE_TICKS > LONG_TICKS) ? STABLE_TICKS : LONG_TICKS;
   localparam int MAX_ALL = (MAX_SL > REPEAT_TICKS) ? MAX_SL : REPEAT_TICKS;
   localparam int CW      = $clog2(MAX_ALL) + 1;

   localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_TICKS - 1);
   localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_TICKS - 1);
`ifdef DEBOUNCE_REPEAT_EN
   localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TICKS - 1);
`endif

   typedef enum logic [1:0] {
      UP,
      DOWN,
      LONG
   } state_t;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == {CW{1'b1}}) ? v : v + 1'b1;
   endfunction

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
      state_t        state;
      logic          sync_a;
      logic          s;
      logic [CW-1:0] deb_cnt;
      logic [CW-1:0] hold_cnt;
`ifdef DEBOUNCE_REPEAT_EN
      logic [CW-1:0] rep_cnt;
`endif
      logic          level;
      logic          press_q;
      logic          release_q;
      logic          long_q;
      logic          toggle_q;
      logic          accept;

      // A change is accepted on the STABLE_TICKS-th consecutive sample that disagrees with the level
      assign accept = (s != level) && (deb_cnt == STABLE_LAST);

      always_ff @(posedge in_clk or negedge in_rst) begin
         if (!in_rst) begin
            state     <= UP;
            sync_a    <= 1'b0;
            s         <= 1'b0;
            deb_cnt   <= '0;
            hold_cnt  <= '0;
`ifdef DEBOUNCE_REPEAT_EN
            rep_cnt   <= '0;
`endif
            level     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            toggle_q  <= 1'b0;
         end else begin
            sync_a    <= in_signal[i];
            s         <= sync_a;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;

            if (s == level || accept)
               deb_cnt <= '0;
            else
               deb_cnt <= sat_inc(deb_cnt);

            // Release acceptance is checked first so it beats the long threshold and repeat tick
            case (state)
               UP: begin
                  if (accept) begin
                     state    <= DOWN;
                     level    <= 1'b1;
                     press_q  <= 1'b1;
                     toggle_q <= ~toggle_q;
                     hold_cnt <= '0;
                  end
               end
               DOWN: begin
                  if (accept) begin
                     state     <= UP;
                     level     <= 1'b0;
                     release_q <= 1'b1;
                  end else if (hold_cnt == LONG_LAST) begin
                     state    <= LONG;
                     long_q   <= 1'b1;
                     hold_cnt <= sat_inc(hold_cnt);
`ifdef DEBOUNCE_REPEAT_EN
                     rep_cnt  <= '0;
`endif
                  end else begin
                     hold_cnt <= sat_inc(hold_cnt);
                  end
               end
               LONG: begin
                  if (accept) begin
                     state     <= UP;
                     level     <= 1'b0;
                     release_q <= 1'b1;
                  end else begin
                     hold_cnt <= sat_inc(hold_cnt);
`ifdef DEBOUNCE_REPEAT_EN
                     if (rep_cnt == REPEAT_LAST) begin
                        press_q <= 1'b1;
                        rep_cnt <= '0;
                     end else begin
                        rep_cnt <= sat_inc(rep_cnt);
                     end
`endif
                  end
               end
               default: begin
                  state <= UP;
                  level <= 1'b0;
               end
            endcase
         end
      end

      assign out_debounced[i] = level;
      assign out_pressed[i]   = press_q;
      assign out_released[i]  = release_q;
      assign out_long[i]      = long_q;
      assign out_toggled[i]   = toggle_q;
   end

endmodule

// File: tb/tb_debounce_buttons_multi.sv
// Directed bench for debounce_buttons_multi; cycle n is the interval after the n-th clock edge of a scenario.
// Expected pulses assume inputs change just after an edge, giving a press pulse 6 cycles later.
module tb_debounce_buttons_multi;

   localparam int NB = 2;
   localparam int ST = 4;
   localparam int LT = 20;
   localparam int RT = 5;
`ifdef DEBOUNCE_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NB-1:0] sig;
   logic [NB-1:0] debounced;
   logic [NB-1:0] pressed;
   logic [NB-1:0] released;
   logic [NB-1:0] long_ev;
   logic [NB-1:0] toggled;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;
   int sc     = 0;

   always #5 clk = ~clk;

   debounce_buttons_multi #(
      .NUM_BTNS(NB),
      .STABLE_TICKS(ST),
      .LONG_TICKS(LT),
      .REPEAT_TICKS(RT)
   ) dut (
      .in_clk(clk),
      .in_rst(rst_n),
      .in_signal(sig),
      .out_debounced(debounced),
      .out_pressed(pressed),
      .out_released(released),
      .out_long(long_ev),
      .out_toggled(toggled)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s (scenario %0d, cycle %0d): got %0h, expected %0h",
                  tag, sc, cycle, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int s_id, input int c);
      rst_n = 1'b1;
      sig   = '0;
      case (s_id)
         1: sig[0] = (c < 10);
         2: sig[0] = (c < 3);
         3: sig[0] = (c < 40);
         4: sig[0] = (c < 30) && !(c == 15 || c == 16);
         5: begin
            sig[0] = (c < 12) || (c >= 20);
            sig[1] = 1'b1;
         end
         6: begin
            sig[0] = 1'b1;
            rst_n  = !(c >= 10 && c < 12);
         end
         default: sig = '0;
      endcase
   endtask

   task automatic checkCycle(input int s_id, input int c);
      logic [NB-1:0] d, p, r, l, t;
      d = '0; p = '0; r = '0; l = '0; t = '0;
      case (s_id)
         1: begin
            d[0] = (c >= 6 && c <= 15);
            p[0] = (c == 6);
            r[0] = (c == 16);
            t[0] = (c >= 6);
         end
         3: begin
            d[0] = (c >= 6 && c <= 45);
            p[0] = (c == 6) || (REP_EN && (c == 31 || c == 36 || c == 41));
            r[0] = (c == 46);
            l[0] = (c == 26);
            t[0] = (c >= 6);
         end
         4: begin
            d[0] = (c >= 6 && c <= 35);
            p[0] = (c == 6) || (REP_EN && c == 31);
            r[0] = (c == 36);
            l[0] = (c == 26);
            t[0] = (c >= 6);
         end
         5: begin
            d[0] = (c >= 6 && c <= 17) || (c >= 26);
            p[0] = (c == 6) || (c == 26);
            r[0] = (c == 18);
            t[0] = (c >= 6 && c < 26);
            d[1] = (c >= 6);
            p[1] = (c == 6) || (REP_EN && c == 31);
            l[1] = (c == 26);
            t[1] = (c >= 6);
         end
         6: begin
            d[0] = (c >= 6 && c < 10) || (c >= 18);
            p[0] = (c == 6) || (c == 18);
            t[0] = d[0];
         end
         default: d = '0;
      endcase
      checkOutput("debounced", 32'(debounced), 32'(d));
      checkOutput("pressed",   32'(pressed),   32'(p));
      checkOutput("released",  32'(released),  32'(r));
      checkOutput("long",      32'(long_ev),   32'(l));
      checkOutput("toggled",   32'(toggled),   32'(t));
   endtask

   task automatic runScenario(input int s_id, input int last);
      sc    = s_id;
      rst_n = 1'b0;
      sig   = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int c = 0; c <= last; c++) begin
         cycle = c;
         applyStimulus(s_id, c);
         #1;
         checkCycle(s_id, c);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      sig   = '1;
      #2;
      checkOutput("reset_debounced", 32'(debounced), 32'd0);
      checkOutput("reset_pressed",   32'(pressed),   32'd0);
      checkOutput("reset_toggled",   32'(toggled),   32'd0);
      runScenario(1, 20);
      runScenario(2, 12);
      runScenario(3, 50);
      runScenario(4, 40);
      runScenario(5, 32);
      runScenario(6, 22);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/debounce_buttons_multi.md
DEBOUNCE_BUTTONS_MULTI -- requirements
Module: debounce_buttons_multi

Interface
REQ-001 SHALL have parameter NUM_BTNS, default 4: number of independent button channels (>=1).
REQ-002 SHALL have parameter STABLE_TICKS, default 50: consecutive synchronised samples needed to accept a level change (>=1).
REQ-003 SHALL have parameter LONG_TICKS, default 1000: cycles after the accepted press until the long-press event (>=1).
REQ-004 SHALL have parameter REPEAT_TICKS, default 200: auto-repeat period in cycles (>=1; used only with DEBOUNCE_REPEAT_EN).
REQ-005 SHALL have port in_clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port in_rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port in_signal  input  NUM_BTNS  raw asynchronous button inputs, bit i = channel i, 1 = pressed.
REQ-008 SHALL have port out_debounced  output  NUM_BTNS  debounced level per channel.
REQ-009 SHALL have port out_pressed  output  NUM_BTNS  one-cycle pulse per accepted press (and per auto-repeat).
REQ-010 SHALL have port out_released  output  NUM_BTNS  one-cycle pulse per accepted release.
REQ-011 SHALL have port out_long  output  NUM_BTNS  one-cycle pulse when a press reaches LONG_TICKS.
REQ-012 SHALL have port out_toggled  output  NUM_BTNS  state flipped on every accepted press.

Function
REQ-013 Each in_signal bit SHALL pass through a 2-flop synchroniser; all logic below uses the synchronised value s[i].
REQ-014 Channels SHALL be fully independent: separate FSM, debounce counter, hold counter, repeat counter.
REQ-015 Per-channel FSM states SHALL be UP (level 0), DOWN (level 1), LONG (level 1, long-press reached); out_debounced[i] = 1 in DOWN and LONG.
REQ-016 Debounce counter SHALL increment each cycle s[i] differs from out_debounced[i] and clear to 0 on any cycle they agree.
REQ-017 A level change SHALL be accepted on the STABLE_TICKS-th consecutive differing sample; counter clears on acceptance.
REQ-018 UP->DOWN on accepted press: out_pressed[i] pulses, out_toggled[i] inverts, hold counter clears.
REQ-019 Press pulse latency SHALL be exactly STABLE_TICKS+2 cycles after the first edge sampling in_signal[i] high, given a stable input.
REQ-020 DOWN: hold counter increments every cycle; on its LONG_TICKS-th cycle the FSM enters LONG and out_long[i] pulses, i.e. out_long exactly LONG_TICKS cycles after out_pressed.
REQ-021 Release glitches shorter than STABLE_TICKS SHALL neither reset the hold counter nor alter any output.
REQ-022 DOWN or LONG -> UP on accepted release: out_released[i] pulses; out_toggled unchanged.
REQ-023 Release acceptance in the same cycle as long threshold or repeat tick SHALL win: UP entered, only out_released pulses.
REQ-024 All outputs SHALL be registered; pulses last exactly one cycle; no two of out_pressed/out_released/out_long pulse together on one channel.
REQ-025 Counter widths SHALL be $clog2 of the largest of STABLE_TICKS, LONG_TICKS, REPEAT_TICKS, plus 1; counters SHALL saturate, never wrap.

Reset
REQ-026 in_rst low SHALL immediately force all channels to UP, clear synchronisers and counters, and drive every output to 0, regardless of clock.
REQ-027 Reset release mid-press SHALL restart debouncing from UP; a held button is re-accepted after STABLE_TICKS+2 cycles.

Configuration
REQ-028 Macro DEBOUNCE_REPEAT_EN defined: in LONG, out_pressed[i] SHALL pulse every REPEAT_TICKS cycles, first REPEAT_TICKS cycles after out_long; repeat pulses do not flip out_toggled.
REQ-029 DEBOUNCE_REPEAT_EN undefined: no repeat counter logic; out_pressed pulses only on UP->DOWN; REPEAT_TICKS ignored.

Verification (NUM_BTNS=2, STABLE_TICKS=4, LONG_TICKS=20, REPEAT_TICKS=5)
REQ-030 Ch0 high from cycle 0, held 10 cycles -> out_pressed[0] single pulse at cycle 6, out_toggled[0]=1, out_debounced[0]=1; ch1 outputs stay 0.
REQ-031 Ch0 pulsed high for 3 cycles then low -> no pulse on any output, out_debounced[0] stays 0.
REQ-032 Ch0 held 40 cycles -> out_long[0] at cycle 26; with DEBOUNCE_REPEAT_EN extra out_pressed[0] at 31, 36, 41; without, none.
REQ-033 Ch0 held with 2-cycle low glitch at cycle 15 -> no release, out_long[0] still at cycle 26.
REQ-034 Ch0 and ch1 pressed, ch0 released after 12 cycles -> out_released[0] pulse 6 cycles after input low; ch1 unaffected; second ch0 press returns out_toggled[0] to 0.
REQ-035 in_rst low mid-hold at cycle 10 -> all outputs 0 asynchronously; after release with input still high, out_pressed[0] exactly 6 cycles later.
